// File: rtl/morse_decoder_if.sv
// Receive-side Morse link bundle: serial line and bit tick in, decoded letter and status out.
// MORSE_DEC_ERR_EN adds the ErrorOut pulse to the bundle.
interface morse_decoder_if;
  logic       DotDashIn;
  logic       NewBitIn;
  logic [2:0] LetterOut;
  logic       LetterValid;
  logic       BusyOut;
`ifdef MORSE_DEC_ERR_EN
  logic       ErrorOut;
`endif

  modport master (
    output DotDashIn, NewBitIn,
    input  LetterOut, LetterValid, BusyOut
`ifdef MORSE_DEC_ERR_EN
    , input ErrorOut
`endif
  );

  modport slave (
    input  DotDashIn, NewBitIn,
    output LetterOut, LetterValid, BusyOut
`ifdef MORSE_DEC_ERR_EN
    , output ErrorOut
`endif
  );
endinterface

// File: rtl/morse_decoder.sv
// Morse receiver decoding A..H; LetterValid pulses the cycle after the tick sampling the last gap zero.
// No backpressure: every tick is consumed. MORSE_DEC_ERR_EN enables the ErrorOut pulse for malformed letters.
module morse_decoder #(
  parameter int DASH_BITS   = 3,
  parameter int GAP_BITS    = 3,
  parameter int MAX_SYMBOLS = 4
) (
  input  logic           ClockIn,
  input  logic           Reset,
  morse_decoder_if.slave rx
);
  localparam int MW = $clog2(DASH_BITS + 2);
  localparam int SW = $clog2(GAP_BITS + 1);
  localparam int CW = $clog2(MAX_SYMBOLS + 1);

  localparam logic [MW-1:0] MARK_DOT   = MW'(1);
  localparam logic [MW-1:0] MARK_DASH  = MW'(DASH_BITS);
  localparam logic [MW-1:0] MARK_SAT   = MW'(DASH_BITS + 1);
  localparam logic [SW-1:0] SPACE_LAST = SW'(GAP_BITS - 1);
  localparam logic [CW-1:0] SYM_MAX    = CW'(MAX_SYMBOLS);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  state_t                 state_q,     state_d;
  logic [MW-1:0]          mark_cnt_q,  mark_cnt_d;
  logic [SW-1:0]          space_cnt_q, space_cnt_d;
  logic [CW-1:0]          sym_cnt_q,   sym_cnt_d;
  logic [MAX_SYMBOLS-1:0] sym_reg_q,   sym_reg_d;
  logic                   bad_q,       bad_d;
  logic [2:0]             letter_q,    letter_d;
  logic                   letter_vld_q, letter_vld_d;
`ifdef MORSE_DEC_ERR_EN
  logic                   error_q,     error_d;
`endif
  logic [3:0]             dec;

  // Returns {hit, code}; first symbol sits in the MSB of the used bits, dash = 1.
  function automatic logic [3:0] decode(input logic [CW-1:0] cnt,
                                        input logic [MAX_SYMBOLS-1:0] sym);
    logic [3:0] r;
    r = 4'b0000;
    case (int'(cnt))
      1: if (sym == MAX_SYMBOLS'(4'b0000)) r = {1'b1, 3'd4};
      2: if (sym == MAX_SYMBOLS'(4'b0001)) r = {1'b1, 3'd0};
      3: begin
        if (sym == MAX_SYMBOLS'(4'b0100)) r = {1'b1, 3'd3};
        if (sym == MAX_SYMBOLS'(4'b0110)) r = {1'b1, 3'd6};
      end
      4: begin
        if (sym == MAX_SYMBOLS'(4'b1000)) r = {1'b1, 3'd1};
        if (sym == MAX_SYMBOLS'(4'b1010)) r = {1'b1, 3'd2};
        if (sym == MAX_SYMBOLS'(4'b0010)) r = {1'b1, 3'd5};
        if (sym == MAX_SYMBOLS'(4'b0000)) r = {1'b1, 3'd7};
      end
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    mark_cnt_d   = mark_cnt_q;
    space_cnt_d  = space_cnt_q;
    sym_cnt_d    = sym_cnt_q;
    sym_reg_d    = sym_reg_q;
    bad_d        = bad_q;
    letter_d     = letter_q;
    letter_vld_d = 1'b0;
`ifdef MORSE_DEC_ERR_EN
    error_d      = 1'b0;
`endif
    dec          = decode(sym_cnt_q, sym_reg_q);

    if (rx.NewBitIn) begin
      unique case (state_q)
        IDLE: begin
          if (rx.DotDashIn) begin
            state_d    = MARK;
            mark_cnt_d = MARK_DOT;
            sym_cnt_d  = '0;
            sym_reg_d  = '0;
            bad_d      = 1'b0;
          end
        end
        MARK: begin
          if (rx.DotDashIn) begin
            if (mark_cnt_q != MARK_SAT) mark_cnt_d = mark_cnt_q + 1'b1;
          end else begin
            sym_reg_d = {sym_reg_q[MAX_SYMBOLS-2:0], (mark_cnt_q == MARK_DASH)};
            if (mark_cnt_q != MARK_DOT && mark_cnt_q != MARK_DASH) bad_d = 1'b1;
            if (sym_cnt_q == SYM_MAX) bad_d = 1'b1;
            else                      sym_cnt_d = sym_cnt_q + 1'b1;
            state_d     = SPACE;
            space_cnt_d = SW'(1);
          end
        end
        SPACE: begin
          if (rx.DotDashIn) begin
            state_d    = MARK;
            mark_cnt_d = MARK_DOT;
          end else begin
            space_cnt_d = space_cnt_q + 1'b1;
            if (space_cnt_q == SPACE_LAST) begin
              state_d = IDLE;
              if (!bad_q && dec[3]) begin
                letter_d     = dec[2:0];
                letter_vld_d = 1'b1;
              end
`ifdef MORSE_DEC_ERR_EN
              else error_d = 1'b1;
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q      <= IDLE;
      mark_cnt_q   <= '0;
      space_cnt_q  <= '0;
      sym_cnt_q    <= '0;
      sym_reg_q    <= '0;
      bad_q        <= 1'b0;
      letter_q     <= 3'd0;
      letter_vld_q <= 1'b0;
`ifdef MORSE_DEC_ERR_EN
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mark_cnt_q   <= mark_cnt_d;
      space_cnt_q  <= space_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      sym_reg_q    <= sym_reg_d;
      bad_q        <= bad_d;
      letter_q     <= letter_d;
      letter_vld_q <= letter_vld_d;
`ifdef MORSE_DEC_ERR_EN
      error_q      <= error_d;
`endif
    end
  end

  assign rx.LetterOut   = letter_q;
  assign rx.LetterValid = letter_vld_q;
  assign rx.BusyOut     = (state_q != IDLE);
`ifdef MORSE_DEC_ERR_EN
  assign rx.ErrorOut    = error_q;
`endif
endmodule
